// File: rtl/memory_access_unit.sv
// Load/store unit: decodes DTCM / ITCM / peripheral windows, formats
// sub-word data and reports misaligned, access and timeout faults.
module memory_access_unit #(
    parameter logic [31:0] DTCM_BASE     = 32'h1000,
    parameter logic [31:0] DTCM_SIZE     = 32'h4000,
    parameter logic [31:0] ITCM_BASE     = 32'h5000,
    parameter logic [31:0] ITCM_SIZE     = 32'h4000,
    parameter logic [31:0] PERIPH_BASE   = 32'h0000,
    parameter logic [31:0] PERIPH_SIZE   = 32'h1000,
    parameter bit          ITCM_WRITABLE = 1'b1,
    parameter int unsigned TIMEOUT       = 16,
    localparam int unsigned DAW = $clog2(DTCM_SIZE / 4),
    localparam int unsigned IAW = $clog2(ITCM_SIZE / 4),
    localparam int unsigned PAW = $clog2(PERIPH_SIZE)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           req_valid,
    output logic           req_ready,
    input  logic           req_we,
    input  logic [31:0]    req_addr,
    input  logic [31:0]    req_wdata,
    input  logic [1:0]     req_width,
    input  logic           req_sign_extend,
    output logic           resp_valid,
    output logic [31:0]    resp_rdata,
    output logic           resp_fault,
    output logic [1:0]     resp_fault_code,
    output logic           dtcm_en,
    output logic [3:0]     dtcm_be,
    output logic [DAW-1:0] dtcm_addr,
    output logic [31:0]    dtcm_wdata,
    input  logic [31:0]    dtcm_rdata,
    output logic           itcm_en,
    output logic [3:0]     itcm_be,
    output logic [IAW-1:0] itcm_addr,
    output logic [31:0]    itcm_wdata,
    input  logic [31:0]    itcm_rdata,
    output logic           periph_req,
    output logic           periph_we,
    output logic [3:0]     periph_be,
    output logic [PAW-1:0] periph_addr,
    output logic [31:0]    periph_wdata,
    input  logic [31:0]    periph_rdata,
    input  logic           periph_ack
);

    localparam int unsigned CW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE, TCM_ACC, TCM_DATA, PERIPH_WAIT, RESP
    } state_e;

    typedef enum logic [1:0] {
        T_NONE, T_DTCM, T_ITCM, T_PERIPH
    } tgt_e;

    state_e        state_q, state_d;
    tgt_e          tgt_in, tgt_q;
    logic [31:0]   off_in, off_q;
    logic [31:0]   wdata_q;
    logic [1:0]    alo_q, width_q;
    logic          we_q, sx_q;
    logic [CW-1:0] cnt_q;
    logic          rvalid_q, fault_q;
    logic [31:0]   rdata_q;
    logic [1:0]    code_q;

    logic [31:0] off_d, off_i, off_p;
    logic [1:0]  fc_in;
    logic        tmo;
    logic [3:0]  st_be;
    logic [31:0] st_wd;
    logic [31:0] ld_raw, ld_sh, ld_data;
    logic        unused_ok;

    assign off_d = req_addr - DTCM_BASE;
    assign off_i = req_addr - ITCM_BASE;
    assign off_p = req_addr - PERIPH_BASE;

    // Overlapping windows resolve peripheral first, then DTCM, then ITCM.
    always_comb begin
        tgt_in = T_NONE;
        off_in = '0;
        priority case (1'b1)
            off_p < PERIPH_SIZE: begin tgt_in = T_PERIPH; off_in = off_p; end
            off_d < DTCM_SIZE:   begin tgt_in = T_DTCM;   off_in = off_d; end
            off_i < ITCM_SIZE:   begin tgt_in = T_ITCM;   off_in = off_i; end
            default: ;
        endcase
    end

    always_comb begin
        fc_in = 2'd0;
        if (req_width == 2'b11)
            fc_in = 2'd2;
        else if ((req_width == 2'b01 && req_addr[0]) ||
                 (req_width == 2'b10 && req_addr[1:0] != 2'b00))
            fc_in = 2'd1;
        else if (tgt_in == T_NONE ||
                 (tgt_in == T_ITCM && req_we && !ITCM_WRITABLE))
            fc_in = 2'd2;
    end

    assign tmo = (cnt_q == CW'(TIMEOUT - 1));

    always_comb begin
        st_be = 4'b1111;
        st_wd = wdata_q;
        unique case (width_q)
            2'b00: begin
                st_be = 4'b0001 << alo_q;
                st_wd = {4{wdata_q[7:0]}};
            end
            2'b01: begin
                st_be = alo_q[1] ? 4'b1100 : 4'b0011;
                st_wd = {2{wdata_q[15:0]}};
            end
            default: ;
        endcase
        if (!we_q)
            st_be = 4'b0000;
    end

    always_comb begin
        ld_raw = (tgt_q == T_ITCM) ? itcm_rdata : dtcm_rdata;
        if (state_q == PERIPH_WAIT)
            ld_raw = periph_rdata;
        ld_sh   = ld_raw >> {alo_q, 3'b000};
        ld_data = ld_sh;
        unique case (width_q)
            2'b00: ld_data = {{24{sx_q & ld_sh[7]}}, ld_sh[7:0]};
            2'b01: ld_data = {{16{sx_q & ld_sh[15]}}, ld_sh[15:0]};
            default: ;
        endcase
        if (we_q)
            ld_data = '0;
    end

    always_ff @(posedge clk) begin
        if (rst)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    if (fc_in != 2'd0)
                        state_d = RESP;
                    else if (tgt_in == T_PERIPH)
                        state_d = PERIPH_WAIT;
                    else
                        state_d = TCM_ACC;
                end
            end
            TCM_ACC:     state_d = TCM_DATA;
            TCM_DATA:    state_d = RESP;
            PERIPH_WAIT: if (periph_ack || tmo) state_d = RESP;
            RESP:        state_d = IDLE;
            default:     state_d = IDLE;
        endcase
    end

    always_comb begin
        req_ready    = 1'b0;
        dtcm_en      = 1'b0;
        dtcm_be      = '0;
        dtcm_addr    = '0;
        dtcm_wdata   = '0;
        itcm_en      = 1'b0;
        itcm_be      = '0;
        itcm_addr    = '0;
        itcm_wdata   = '0;
        periph_req   = 1'b0;
        periph_we    = 1'b0;
        periph_be    = '0;
        periph_addr  = '0;
        periph_wdata = '0;
        unique case (state_q)
            IDLE: req_ready = 1'b1;
            TCM_ACC: begin
                if (tgt_q == T_ITCM) begin
                    itcm_en    = 1'b1;
                    itcm_be    = st_be;
                    itcm_addr  = off_q[IAW+1:2];
                    itcm_wdata = st_wd;
                end else begin
                    dtcm_en    = 1'b1;
                    dtcm_be    = st_be;
                    dtcm_addr  = off_q[DAW+1:2];
                    dtcm_wdata = st_wd;
                end
            end
            PERIPH_WAIT: begin
                periph_req   = 1'b1;
                periph_we    = we_q;
                periph_be    = st_be;
                periph_addr  = off_q[PAW-1:0];
                periph_wdata = st_wd;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tgt_q    <= T_NONE;
            off_q    <= '0;
            wdata_q  <= '0;
            alo_q    <= '0;
            width_q  <= '0;
            we_q     <= 1'b0;
            sx_q     <= 1'b0;
            cnt_q    <= '0;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            fault_q  <= 1'b0;
            code_q   <= '0;
        end else begin
            cnt_q    <= (state_q == PERIPH_WAIT) ? cnt_q + 1'b1 : '0;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            fault_q  <= 1'b0;
            code_q   <= '0;
            unique case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        tgt_q   <= tgt_in;
                        off_q   <= off_in;
                        wdata_q <= req_wdata;
                        alo_q   <= req_addr[1:0];
                        width_q <= req_width;
                        we_q    <= req_we;
                        sx_q    <= req_sign_extend;
                        if (fc_in != 2'd0) begin
                            rvalid_q <= 1'b1;
                            fault_q  <= 1'b1;
                            code_q   <= fc_in;
                        end
                    end
                end
                TCM_DATA: begin
                    rvalid_q <= 1'b1;
                    rdata_q  <= ld_data;
                end
                PERIPH_WAIT: begin
                    if (periph_ack) begin
                        rvalid_q <= 1'b1;
                        rdata_q  <= ld_data;
                    end else if (tmo) begin
                        rvalid_q <= 1'b1;
                        fault_q  <= 1'b1;
                        code_q   <= 2'd3;
                    end
                end
                default: ;
            endcase
        end
    end

    assign resp_valid      = rvalid_q;
    assign resp_rdata      = rdata_q;
    assign resp_fault      = fault_q;
    assign resp_fault_code = code_q;

    assign unused_ok = ^off_q;

endmodule

// File: tb/tb_memory_access_unit.sv
// Directed bench for memory_access_unit with a DTCM array model,
// a fixed-pattern ITCM and a scripted peripheral responder.
module tb_memory_access_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_we, req_sign_extend;
    logic [31:0] req_addr, req_wdata;
    logic [1:0]  req_width;
    logic        resp_valid, resp_fault;
    logic [31:0] resp_rdata;
    logic [1:0]  resp_fault_code;
    logic        dtcm_en, itcm_en;
    logic [3:0]  dtcm_be, itcm_be;
    logic [11:0] dtcm_addr, itcm_addr;
    logic [31:0] dtcm_wdata, itcm_wdata, dtcm_rdata, itcm_rdata;
    logic        periph_req, periph_we, periph_ack;
    logic [3:0]  periph_be;
    logic [11:0] periph_addr;
    logic [31:0] periph_wdata, periph_rdata;

    memory_access_unit #(.ITCM_WRITABLE(1'b0)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_width(req_width), .req_sign_extend(req_sign_extend),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .resp_fault(resp_fault), .resp_fault_code(resp_fault_code),
        .dtcm_en(dtcm_en), .dtcm_be(dtcm_be), .dtcm_addr(dtcm_addr),
        .dtcm_wdata(dtcm_wdata), .dtcm_rdata(dtcm_rdata),
        .itcm_en(itcm_en), .itcm_be(itcm_be), .itcm_addr(itcm_addr),
        .itcm_wdata(itcm_wdata), .itcm_rdata(itcm_rdata),
        .periph_req(periph_req), .periph_we(periph_we),
        .periph_be(periph_be), .periph_addr(periph_addr),
        .periph_wdata(periph_wdata), .periph_rdata(periph_rdata),
        .periph_ack(periph_ack)
    );

    always #5 clk = ~clk;

    logic [31:0] dmem [4096];

    always @(posedge clk) begin
        if (dtcm_en) begin
            for (int b = 0; b < 4; b++)
                if (dtcm_be[b])
                    dmem[dtcm_addr][8*b +: 8] <= dtcm_wdata[8*b +: 8];
            dtcm_rdata <= dmem[dtcm_addr];
        end
    end

    always @(posedge clk) begin
        if (itcm_en)
            itcm_rdata <= 32'hCAFE0000 | {20'b0, itcm_addr};
    end

    int n_cmp = 0;
    int n_err = 0;

    int          den_cnt, ien_cnt, preq, mux_err;
    logic [3:0]  obs_be, obs_pbe;
    logic [31:0] obs_addr, obs_wd, obs_pa;
    logic [31:0] r_rd;
    logic [1:0]  r_code;
    logic        r_flt;
    int          r_lat;

    task automatic check(input string tag, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, act, exp);
        end
    endtask

    task automatic run(input logic we, input logic [31:0] a,
                       input logic [31:0] wd, input logic [1:0] w,
                       input logic sx, input int ack_at);
        den_cnt = 0; ien_cnt = 0; preq = 0;
        obs_be = '0; obs_pbe = '0; obs_addr = '0; obs_wd = '0; obs_pa = '0;
        r_rd = 'x; r_code = 'x; r_flt = 1'bx; r_lat = -1;
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_addr = a;
        req_wdata = wd; req_width = w; req_sign_extend = sx;
        @(negedge clk);
        req_valid = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            periph_ack = 1'b0;
            if (int'(dtcm_en) + int'(itcm_en) + int'(periph_req) > 1)
                mux_err++;
            if (dtcm_en) begin
                den_cnt++; obs_be = dtcm_be;
                obs_addr = {20'b0, dtcm_addr}; obs_wd = dtcm_wdata;
            end
            if (itcm_en) begin
                ien_cnt++; obs_be = itcm_be;
                obs_addr = {20'b0, itcm_addr}; obs_wd = itcm_wdata;
            end
            if (periph_req) begin
                preq++; obs_pbe = periph_be; obs_pa = {20'b0, periph_addr};
            end
            if (resp_valid) begin
                r_lat = k; r_rd = resp_rdata;
                r_code = resp_fault_code; r_flt = resp_fault;
                break;
            end
            if (periph_req && preq == ack_at)
                periph_ack = 1'b1;
            @(negedge clk);
        end
    endtask

    initial begin
        int pulses;
        mux_err = 0;
        periph_ack = 1'b0;
        periph_rdata = 32'h0000005A;
        rst = 1'b1;
        req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h1004;
        req_wdata = '0; req_width = 2'b10; req_sign_extend = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_resp_valid", {31'b0, resp_valid}, 0);
        check("rst_dtcm_en", {31'b0, dtcm_en}, 0);
        check("rst_periph_req", {31'b0, periph_req}, 0);
        req_valid = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_ready", {31'b0, req_ready}, 1);
        pulses = 0;
        repeat (3) begin
            @(negedge clk);
            if (resp_valid || dtcm_en) pulses++;
        end
        check("rst_req_ignored", pulses, 0);

        run(1'b1, 32'h1004, 32'hDEADBEEF, 2'b10, 1'b0, 0);
        check("sw_be", obs_be, 4'b1111);
        check("sw_addr", obs_addr, 1);
        check("sw_wdata", obs_wd, 32'hDEADBEEF);
        check("sw_lat", r_lat, 3);
        check("sw_rdata", r_rd, 0);
        @(negedge clk);
        check("resp_one_cycle", {31'b0, resp_valid}, 0);
        check("ready_after_resp", {31'b0, req_ready}, 1);

        run(1'b0, 32'h1004, 32'h0, 2'b10, 1'b0, 0);
        check("lw_be", obs_be, 4'b0000);
        check("lw_lat", r_lat, 3);
        check("lw_rdata", r_rd, 32'hDEADBEEF);
        check("lw_fault", {31'b0, r_flt}, 0);

        run(1'b1, 32'h1004, 32'h80FF0000, 2'b10, 1'b0, 0);
        run(1'b0, 32'h1007, 32'h0, 2'b00, 1'b1, 0);
        check("lb_sx", r_rd, 32'hFFFFFF80);
        run(1'b0, 32'h1007, 32'h0, 2'b00, 1'b0, 0);
        check("lbu", r_rd, 32'h00000080);

        run(1'b1, 32'h1002, 32'h0000ABCD, 2'b01, 1'b0, 0);
        check("sh_be", obs_be, 4'b1100);
        check("sh_wdata", obs_wd, 32'hABCDABCD);
        check("sh_addr", obs_addr, 0);
        run(1'b0, 32'h1002, 32'h0, 2'b01, 1'b1, 0);
        check("lh_sx", r_rd, 32'hFFFFABCD);
        run(1'b0, 32'h1002, 32'h0, 2'b01, 1'b0, 0);
        check("lhu", r_rd, 32'h0000ABCD);

        run(1'b1, 32'h1009, 32'hFFFFFF12, 2'b00, 1'b0, 0);
        check("sb_be", obs_be, 4'b0010);
        check("sb_wdata", obs_wd, 32'h12121212);
        run(1'b0, 32'h1009, 32'h0, 2'b00, 1'b1, 0);
        check("lb_pos", r_rd, 32'h00000012);

        run(1'b0, 32'h1001, 32'h0, 2'b01, 1'b0, 0);
        check("mis_code", r_code, 1);
        check("mis_fault", {31'b0, r_flt}, 1);
        check("mis_lat", r_lat, 1);
        check("mis_no_en", den_cnt, 0);
        check("mis_rdata", r_rd, 0);
        run(1'b0, 32'h1002, 32'h0, 2'b10, 1'b0, 0);
        check("mis_word", r_code, 1);
        run(1'b0, 32'h9001, 32'h0, 2'b01, 1'b0, 0);
        check("mis_before_win", r_code, 1);
        run(1'b0, 32'h9000, 32'h0, 2'b10, 1'b0, 0);
        check("oow_code", r_code, 2);
        check("oow_lat", r_lat, 1);
        run(1'b0, 32'h1004, 32'h0, 2'b11, 1'b0, 0);
        check("rsv_code", r_code, 2);
        run(1'b0, 32'h1001, 32'h0, 2'b11, 1'b0, 0);
        check("rsv_first", r_code, 2);

        run(1'b0, 32'h4FFC, 32'h0, 2'b10, 1'b0, 0);
        check("dtcm_top_code", r_code, 0);
        check("dtcm_top_addr", obs_addr, 32'hFFF);
        check("dtcm_top_lat", r_lat, 3);

        run(1'b0, 32'h0800, 32'h0, 2'b10, 1'b0, 4);
        check("pl_req_cycles", preq, 4);
        check("pl_addr", obs_pa, 32'h800);
        check("pl_rdata", r_rd, 32'h5A);
        check("pl_lat", r_lat, 5);
        check("pl_code", r_code, 0);
        run(1'b0, 32'h0800, 32'h0, 2'b10, 1'b0, 0);
        check("pto_code", r_code, 3);
        check("pto_req_cycles", preq, 16);
        check("pto_rdata", r_rd, 0);
        check("pto_lat", r_lat, 17);
        run(1'b0, 32'h0800, 32'h0, 2'b10, 1'b0, 16);
        check("plast_code", r_code, 0);
        check("plast_rdata", r_rd, 32'h5A);
        run(1'b1, 32'h0FFC, 32'h11223344, 2'b10, 1'b0, 1);
        check("ps_be", obs_pbe, 4'b1111);
        check("ps_lat", r_lat, 2);
        check("ps_rdata", r_rd, 0);

        run(1'b1, 32'h5000, 32'h12345678, 2'b10, 1'b0, 0);
        check("itcm_st_code", r_code, 2);
        check("itcm_st_no_en", ien_cnt, 0);
        run(1'b0, 32'h5000, 32'h0, 2'b10, 1'b0, 0);
        check("itcm_ld_code", r_code, 0);
        check("itcm_ld_rdata", r_rd, 32'hCAFE0000);
        run(1'b0, 32'h5003, 32'h0, 2'b00, 1'b1, 0);
        check("itcm_lb_sx", r_rd, 32'hFFFFFFCA);

        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h0800;
        req_width = 2'b10; req_sign_extend = 1'b0;
        @(negedge clk);
        req_valid = 1'b0;
        check("rst_mid_req", {31'b0, periph_req}, 1);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid_req_low", {31'b0, periph_req}, 0);
        check("rst_mid_no_resp", {31'b0, resp_valid}, 0);
        rst = 1'b0;
        @(negedge clk);
        check("rst_mid_ready", {31'b0, req_ready}, 1);
        pulses = 0;
        repeat (20) begin
            @(negedge clk);
            if (resp_valid || periph_req) pulses++;
        end
        check("rst_mid_abandon", pulses, 0);

        check("mutex", mux_err, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
